regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Write-side producer for the 16x16 register file. Buffers writeback results from the ALU and load paths in a small in-order FIFO and drains one entry per cycle into the register file write port (WriteReg/WriteData/WE).
- Reports pending writes and forwards the youngest pending data for the two read-port addresses, so the decode stage can bypass or stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 4, register address width (16 registers).
- DW, 16, data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result request
- alu_reg  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load result request
- ld_reg  in  AW  load destination register
- ld_data  in  DW  load data
- ld_ready  out  1  load request accepted this cycle
- WriteReg  out  AW  register file write address (registered)
- WriteData  out  DW  register file write data (registered)
- WE  out  1  register file write enable (registered)
- a_reg  in  AW  read-port A address to check
- b_reg  in  AW  read-port B address to check
- a_pending  out  1  write to a_reg is queued or on the output stage
- a_fwd  out  DW  youngest pending data for a_reg
- b_pending  out  1  write to b_reg is queued or on the output stage
- b_fwd  out  DW  youngest pending data for b_reg
- count  out  clog2(DEPTH)+1  occupancy (FIFO only)
- empty  out  1  count==0 and WE==0

Behaviour:
- Reset (synchronous, rst high at a rising edge): head, tail and count go to 0. WE=0, WriteReg=0, WriteData=0. Entry contents are don't-care. rst overrides any push or pop in the same cycle; requests presented during reset are dropped.
- Accept, at most one per cycle:
  - ld_ready = (count<DEPTH).
  - alu_ready = (count<DEPTH) && !ld_valid. Load has fixed priority.
  - Push on ld_valid&&ld_ready, else on alu_valid&&alu_ready.
  - Combinational readies; no pass-through when full. A pop in the same cycle does not free a slot for that cycle's accept.
- Drain: every cycle with count>0 (and no reset), pop the head into the output stage: WriteReg<=head.reg, WriteData<=head.data, WE<=1. If count==0, WE<=0 and WriteReg/WriteData hold their values.
- Latency:
  - Request accepted at edge N (empty queue) -> WE=1 during the cycle after edge N+1.
  - Register file commits at edge N+2.
  - Sustained throughput is 1 write per cycle.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged.
  - Pointers wrap modulo DEPTH.
- Ordering: strict FIFO. Two writes to the same register commit in acceptance order; the later value wins in the register file.
- Pending/forward (combinational, per port; B mirrors A):
  - Candidates are valid FIFO entries plus the output stage (when WE=1).
  - a_pending=1 if any candidate has reg==a_reg.
  - a_fwd takes the data of the youngest match, in order tail-1 … head, then the output stage. With no match, a_fwd=0.
  - Entries pushed in the current cycle are not visible until the next cycle.
  - Register 0 has no special treatment; it is writable.
- The output stage never stalls; the register file write port always accepts.

Test Plan:
- Reset: drive rst with alu_valid=1 -> after the edge, WE=0, count=0, empty=1; request not queued.
- Single write: alu_valid with reg=3, data=0x1234, accepted at edge N -> WE=1, WriteReg=3, WriteData=0x1234 for exactly one cycle after edge N+1, then WE=0.
- Priority: ld(reg 5, 0xAAAA) and alu(reg 6, 0x5555) valid together -> ld_ready=1, alu_ready=0. Load is output first; ALU accepted next cycle and output one cycle later.
- Full: hold alu_valid for 6 cycles with the drain active -> count saturates below DEPTH or readies drop at count==DEPTH. No entry lost or duplicated; outputs appear in order.
- Forwarding: queue reg 7 = 0x0001 then reg 7 = 0x0002, with a_reg=7 -> a_pending=1, a_fwd=0x0002. After both drain, a_pending=0, a_fwd=0.
- Reset mid-operation: 3 entries queued, assert rst -> the next cycle shows WE=0 and count=0, and no further writes are issued.

Source files
------------

// File: rtl/regfile_write_queue.sv
// In-order writeback queue feeding the register file write port, one write per cycle.
// Also reports pending writes and forwards the youngest pending data for two read ports.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_reg,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_reg,
    input  logic [DW-1:0]            ld_data,
    output logic                     ld_ready,
    output logic [AW-1:0]            WriteReg,
    output logic [DW-1:0]            WriteData,
    output logic                     WE,
    input  logic [AW-1:0]            a_reg,
    input  logic [AW-1:0]            b_reg,
    output logic                     a_pending,
    output logic [DW-1:0]            a_fwd,
    output logic                     b_pending,
    output logic [DW-1:0]            b_fwd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [AW-1:0] slot_reg  [DEPTH];
    logic [DW-1:0] slot_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_reg;
    logic [DW-1:0] push_data;

    // Load has fixed priority; a same-cycle pop never frees a slot for this cycle's accept.
    assign ld_ready  = (count != FULL_COUNT);
    assign alu_ready = (count != FULL_COUNT) && !ld_valid;
    assign push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    assign push_reg  = ld_valid ? ld_reg  : alu_reg;
    assign push_data = ld_valid ? ld_data : alu_data;
    assign pop       = (count != '0);
    assign empty     = (count == '0) && !WE;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            slot_reg[tail]  <= push_reg;
            slot_data[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            WE        <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head      <= head + 1'b1;
                WE        <= 1'b1;
                WriteReg  <= slot_reg[head];
                WriteData <= slot_data[head];
            end else begin
                WE <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so later matches override; the output stage is older than any entry.
    function automatic logic [DW:0] find_youngest(input logic [AW-1:0] addr);
        logic [DW:0]   hit;
        logic [PW-1:0] idx;
        hit = '0;
        if (WE && WriteReg == addr) begin
            hit = {1'b1, WriteData};
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < count) && slot_reg[idx] == addr) begin
                hit = {1'b1, slot_data[idx]};
            end
        end
        return hit;
    endfunction

    assign {a_pending, a_fwd} = find_youngest(a_reg);
    assign {b_pending, b_fwd} = find_youngest(b_reg);

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_reg;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic          WE;
    logic [AW-1:0] a_reg;
    logic [AW-1:0] b_reg;
    logic          a_pending;
    logic [DW-1:0] a_fwd;
    logic          b_pending;
    logic [DW-1:0] b_fwd;
    logic [CW-1:0] count;
    logic          empty;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
        .WriteReg(WriteReg), .WriteData(WriteData), .WE(WE),
        .a_reg(a_reg), .b_reg(b_reg),
        .a_pending(a_pending), .a_fwd(a_fwd), .b_pending(b_pending), .b_fwd(b_fwd),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    // Reference model: pending writes in acceptance order plus the register-file output stage.
    wr_t           q[$];
    logic          m_we;
    logic [AW-1:0] m_wr;
    logic [DW-1:0] m_wd;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW:0] m_lookup(input logic [AW-1:0] addr);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].r == addr) return {1'b1, q[i].d};
        end
        if (m_we && m_wr == addr) return {1'b1, m_wd};
        return '0;
    endfunction

    task automatic drive(input logic r, input logic av, input logic [AW-1:0] ar,
                         input logic [DW-1:0] ad, input logic lv, input logic [AW-1:0] lr,
                         input logic [DW-1:0] ldd);
        rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
        ld_valid = lv; ld_reg = lr; ld_data = ldd;
    endtask

    task automatic tick();
        bit  acc;
        wr_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_we = 1'b0; m_wr = '0; m_wd = '0;
        end else begin
            acc = 1'b0;
            e   = '0;
            if (ld_valid && q.size() < DEPTH) begin
                acc = 1'b1; e = {ld_reg, ld_data};
            end else if (alu_valid && q.size() < DEPTH) begin
                acc = 1'b1; e = {alu_reg, alu_data};
            end
            if (q.size() > 0) begin
                m_we = 1'b1; m_wr = q[0].r; m_wd = q[0].d;
                void'(q.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        a_reg = 4'd0; b_reg = 4'd1;
        drive(1'b1, 1'b1, 4'd2, 16'hBEEF, 1'b0, 4'd0, 16'h0);
        tick();
        tick();
        checks++; if (WE !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", WE); end
        checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        tick();
        checks++; if (WE !== 1'b0 || count !== '0) begin errors++;
            $display("[TB] FAIL reset_dropped: got WE=%b count=%0d expected WE=0 count=0", WE, count); end
    endtask

    task automatic test_single();
        drive(1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", alu_ready); end
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checks++; if (WE !== 1'b0 || count !== CW'(1)) begin errors++;
            $display("[TB] FAIL single_queued: got WE=%b count=%0d expected WE=0 count=1", WE, count); end
        tick();
        checks++; if ({WE, WriteReg, WriteData} !== {1'b1, 4'd3, 16'h1234}) begin errors++;
            $display("[TB] FAIL single_out: got %b/%0d/%h expected 1/3/1234", WE, WriteReg, WriteData); end
        tick();
        checks++; if (WE !== 1'b0 || empty !== 1'b1) begin errors++;
            $display("[TB] FAIL single_done: got WE=%b empty=%b expected 0/1", WE, empty); end
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b1, 4'd6, 16'h5555, 1'b1, 4'd5, 16'hAAAA);
        #1;
        checks++; if ({ld_ready, alu_ready} !== 2'b10) begin errors++;
            $display("[TB] FAIL prio_ready: got ld=%b alu=%b expected 1/0", ld_ready, alu_ready); end
        tick();
        drive(1'b0, 1'b1, 4'd6, 16'h5555, 1'b0, 4'd0, 16'h0);
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_alu_ready: got %b expected 1", alu_ready); end
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checks++; if ({WE, WriteReg, WriteData} !== {1'b1, 4'd5, 16'hAAAA}) begin errors++;
            $display("[TB] FAIL prio_first: got %b/%0d/%h expected 1/5/aaaa", WE, WriteReg, WriteData); end
        tick();
        checks++; if ({WE, WriteReg, WriteData} !== {1'b1, 4'd6, 16'h5555}) begin errors++;
            $display("[TB] FAIL prio_second: got %b/%0d/%h expected 1/6/5555", WE, WriteReg, WriteData); end
        tick();
        checks++; if (WE !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle: got %b expected 0", WE); end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp_data[$];
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, AW'(i + 8), DW'(16'hC000 + i), 1'b0, 4'd0, 16'h0);
            #1;
            checks++; if (alu_ready !== (count < CW'(DEPTH))) begin errors++;
                $display("[TB] FAIL full_ready%0d: got %b count=%0d", i, alu_ready, count); end
            if (alu_ready === 1'b1) exp_data.push_back(DW'(16'hC000 + i));
            tick();
            if (WE === 1'b1) begin
                checks++;
                if (exp_data.size() == 0 || WriteData !== exp_data[0]) begin errors++;
                    $display("[TB] FAIL full_order%0d: got %h expected %h", i, WriteData,
                             exp_data.size() ? exp_data[0] : 16'h0);
                end
                if (exp_data.size() != 0) void'(exp_data.pop_front());
            end
        end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
            if (WE === 1'b1) begin
                checks++;
                if (exp_data.size() == 0 || WriteData !== exp_data[0]) begin errors++;
                    $display("[TB] FAIL full_drain%0d: got %h", i, WriteData); end
                if (exp_data.size() != 0) void'(exp_data.pop_front());
            end
        end
        checks++; if (exp_data.size() != 0 || empty !== 1'b1) begin errors++;
            $display("[TB] FAIL full_lost: got %0d undrained, empty=%b expected 0 undrained, empty=1", exp_data.size(), empty); end
    endtask

    task automatic test_forwarding();
        a_reg = 4'd7; b_reg = 4'd8;
        drive(1'b0, 1'b1, 4'd7, 16'h0001, 1'b0, 4'd0, 16'h0);
        #1;
        checks++; if (a_pending !== 1'b0) begin errors++; $display("[TB] FAIL fwd_same_cycle: got %b expected 0", a_pending); end
        tick();
        drive(1'b0, 1'b1, 4'd7, 16'h0002, 1'b0, 4'd0, 16'h0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checks++; if ({a_pending, a_fwd} !== {1'b1, 16'h0002}) begin errors++;
            $display("[TB] FAIL fwd_youngest: got %b/%h expected 1/0002", a_pending, a_fwd); end
        checks++; if ({b_pending, b_fwd} !== {1'b0, 16'h0}) begin errors++;
            $display("[TB] FAIL fwd_nomatch: got %b/%h expected 0/0000", b_pending, b_fwd); end
        tick();
        checks++; if ({a_pending, a_fwd} !== {1'b1, 16'h0002}) begin errors++;
            $display("[TB] FAIL fwd_outstage: got %b/%h expected 1/0002", a_pending, a_fwd); end
        tick();
        checks++; if ({a_pending, a_fwd} !== {1'b0, 16'h0}) begin errors++;
            $display("[TB] FAIL fwd_drained: got %b/%h expected 0/0000", a_pending, a_fwd); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, AW'(i + 1), DW'(16'h7700 + i), 1'b0, 4'd0, 16'h0);
            tick();
        end
        drive(1'b1, 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checks++; if (WE !== 1'b0 || count !== '0) begin errors++;
            $display("[TB] FAIL rstmid_state: got WE=%b count=%0d expected 0/0", WE, count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (WE !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_quiet%0d: got %b expected 0", i, WE); end
        end
    endtask

    task automatic test_random();
        logic [DW:0] exp_a;
        logic [DW:0] exp_b;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), AW'($urandom_range(0, 3)),
                  DW'($urandom), ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 3)), DW'($urandom));
            a_reg = AW'($urandom_range(0, 3));
            b_reg = AW'($urandom_range(0, 3));
            #1;
            exp_a = m_lookup(a_reg);
            exp_b = m_lookup(b_reg);
            checks++; if ({a_pending, a_fwd} !== exp_a) begin errors++;
                $display("[TB] FAIL rnd_a%0d: got %b/%h expected %b/%h", i, a_pending, a_fwd, exp_a[DW], exp_a[DW-1:0]); end
            checks++; if ({b_pending, b_fwd} !== exp_b) begin errors++;
                $display("[TB] FAIL rnd_b%0d: got %b/%h expected %b/%h", i, b_pending, b_fwd, exp_b[DW], exp_b[DW-1:0]); end
            checks++; if ({ld_ready, alu_ready} !== {q.size() < DEPTH, (q.size() < DEPTH) && !ld_valid}) begin errors++;
                $display("[TB] FAIL rnd_ready%0d: got ld=%b alu=%b model size=%0d", i, ld_ready, alu_ready, q.size()); end
            tick();
            checks++; if ({WE, WriteReg, WriteData} !== {m_we, m_wr, m_wd}) begin errors++;
                $display("[TB] FAIL rnd_out%0d: got %b/%0d/%h expected %b/%0d/%h", i, WE, WriteReg, WriteData, m_we, m_wr, m_wd); end
            checks++; if (count !== CW'(q.size()) || empty !== (q.size() == 0 && !m_we)) begin errors++;
                $display("[TB] FAIL rnd_count%0d: got %0d/%b expected %0d", i, count, empty, q.size()); end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        a_reg = 4'd0; b_reg = 4'd0;
        q.delete(); m_we = 1'b0; m_wr = '0; m_wd = '0;
        test_reset();
        test_single();
        test_priority();
        test_full();
        test_forwarding();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
